audio_i2s_tx: RTL

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_i2s_tx.sv | 96 +++++++++
 1 files changed

// File: rtl/audio_i2s_tx.sv
// I2S (Philips) stereo transmitter: 32 BCK per frame, one-deep holding buffer,
// frame load with zero-latency bypass when the buffer is empty.
module audio_i2s_tx #(
  parameter int CLK_DIV     = 8,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SAMPLE_BITS-1:0] left_in,
  input  logic [SAMPLE_BITS-1:0] right_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   underrun,
  output logic                   i2s_bck,
  output logic                   i2s_lrck,
  output logic                   i2s_data
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]          div;
  logic [4:0]             bit_cnt;
  logic [SAMPLE_BITS-1:0] left_work, right_work;
  logic [SAMPLE_BITS-1:0] hold_l, hold_r;
  logic                   hold_full;

  logic                     term, fall_tick, load, transfer;
  logic [4:0]               nxt_cnt, bit_idx;
  logic [SAMPLE_BITS-1:0]   ld_l, ld_r;
  logic [2*SAMPLE_BITS-1:0] frame;

  assign sample_ready = ~hold_full;

  always_comb begin
    term      = (div == DW'(CLK_DIV - 1));
    fall_tick = term & i2s_bck;
    nxt_cnt   = bit_cnt + 5'd1;
    load      = fall_tick & (nxt_cnt == 5'd1);
    transfer  = sample_valid & ~hold_full;
    ld_l      = left_work;
    ld_r      = right_work;
    if (load && hold_full) begin
      ld_l = hold_l;
      ld_r = hold_r;
    end else if (load && sample_valid) begin
      ld_l = left_in;
      ld_r = right_in;
    end
    // One-bit Philips delay: counter k drives stream bit k-1 of {left, right}.
    frame   = {ld_l, ld_r};
    bit_idx = ~(nxt_cnt - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      i2s_bck    <= 1'b0;
      i2s_lrck   <= 1'b1;
      i2s_data   <= 1'b0;
      bit_cnt    <= 5'd31;
      left_work  <= '0;
      right_work <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_full  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (term) begin
        div     <= '0;
        i2s_bck <= ~i2s_bck;
      end else begin
        div <= div + 1'b1;
      end

      if (fall_tick) begin
        bit_cnt  <= nxt_cnt;
        i2s_data <= frame[bit_idx];
        if (nxt_cnt == 5'd0)       i2s_lrck <= 1'b0;
        else if (nxt_cnt == 5'd16) i2s_lrck <= 1'b1;
        if (load) begin
          left_work  <= ld_l;
          right_work <= ld_r;
          if (hold_full)          hold_full <= 1'b0;
          else if (!sample_valid) underrun  <= 1'b1;
        end
      end

      // A bypass load consumes the transfer, so only fill when not loading.
      if (transfer && !load) begin
        hold_l    <= left_in;
        hold_r    <= right_in;
        hold_full <= 1'b1;
      end
    end
  end
endmodule
